// File: rtl/pkt_streamer_pkg.sv
// Shared constants for the packet RAM streamer: default widths, header length field and
// FSM state encoding.
package pkt_streamer_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 6;

   localparam int unsigned LEN_LSB = 0;
   localparam int unsigned LEN_MSB = 5;
   localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StRdHdr   = 2'd1;
   localparam state_t StWaitHdr = 2'd2;
   localparam state_t StStream  = 2'd3;

endpackage

// File: rtl/pkt_skid_fifo.sv
// Two-entry buffer between the RAM read port and the stream output; push and pop may
// coincide even when full.
module pkt_skid_fifo #(
   parameter int unsigned WIDTH = 34
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [1:0]       occ_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       occ_q;

   assign rdata_o = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

endmodule

// File: rtl/pkt_ram_streamer.sv
// Reads one length-prefixed packet from the packet RAM on a send_cmd rising edge and
// streams the payload out with sop/eop framing and full ready backpressure.
module pkt_ram_streamer
   import pkt_streamer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send_cmd,
   input  logic [ADDR_W-1:0] start_ram_addr,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              st_valid,
   output logic [DATA_W-1:0] st_data,
   output logic              st_sop,
   output logic              st_eop,
   input  logic              st_ready,
   output logic              busy,
   output logic              pkt_done,
   output logic              len_err,
   output logic [15:0]       pkt_count
);

   localparam int unsigned FIFO_W = DATA_W + 2;

   state_t            state_q, state_d;
   logic              send_q;
   logic [ADDR_W-1:0] start_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued_q;
   logic [LEN_W-1:0]  recv_q;
   logic              rd_pend_q;
   logic              len_err_q;
   logic              pkt_done_q;
   logic [15:0]       pkt_count_q;

   logic              start_edge;
   logic              issue;
   logic              pop;
   logic              eop_hs;
   logic [1:0]        occ;
   logic [1:0]        occ_after;
   logic [LEN_W-1:0]  hdr_len;
   logic [FIFO_W-1:0] fifo_wdata;
   logic [FIFO_W-1:0] fifo_rdata;

   assign start_edge = send_cmd & ~send_q;
   assign hdr_len    = ram_rd_data[LEN_MSB:LEN_LSB];
   assign st_valid   = (occ != 2'd0);
   assign pop        = st_valid & st_ready;
   assign eop_hs     = pop & st_eop;
   assign occ_after  = occ - {1'b0, pop};

   // Buffered words plus reads still in flight may never exceed the two buffer slots.
   assign issue = (state_q == StStream) && ((occ_after + {1'b0, rd_pend_q}) < 2'd2) &&
                  (issued_q < len_q);

   // Framing is tagged as data returns, so the buffer carries sop/eop alongside each word.
   assign fifo_wdata = {(recv_q == '0), (recv_q == (len_q - LEN_W'(1))), ram_rd_data};

   assign {st_sop, st_eop, st_data} = fifo_rdata;
   assign ram_rd_en = (state_q == StRdHdr) | issue;
   assign busy      = (state_q != StIdle);
   assign pkt_done  = pkt_done_q;
   assign len_err   = len_err_q;
   assign pkt_count = pkt_count_q;

   always_comb begin
      ram_rd_addr = '0;
      if (state_q == StRdHdr) begin
         ram_rd_addr = start_q;
      end else if (issue) begin
         ram_rd_addr = start_q + ADDR_W'(issued_q) + ADDR_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_edge) state_d = StRdHdr;
         StRdHdr:   state_d = StWaitHdr;
         StWaitHdr: state_d = (hdr_len == '0) ? StIdle : StStream;
         StStream:  if (eop_hs) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         send_q      <= 1'b0;
         start_q     <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         recv_q      <= '0;
         rd_pend_q   <= 1'b0;
         len_err_q   <= 1'b0;
         pkt_done_q  <= 1'b0;
         pkt_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         send_q     <= send_cmd;
         rd_pend_q  <= issue;
         len_err_q  <= (state_q == StWaitHdr) && (hdr_len == '0);
         pkt_done_q <= eop_hs;
         if (eop_hs) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
         if ((state_q == StIdle) && start_edge) begin
            start_q <= start_ram_addr;
         end
         if (state_q == StWaitHdr) begin
            len_q    <= hdr_len;
            issued_q <= '0;
            recv_q   <= '0;
         end else begin
            if (issue) begin
               issued_q <= issued_q + LEN_W'(1);
            end
            if (rd_pend_q) begin
               recv_q <= recv_q + LEN_W'(1);
            end
         end
      end
   end

   pkt_skid_fifo #(
      .WIDTH (FIFO_W)
   ) u_skid_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (rd_pend_q),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .occ_o   (occ)
   );

endmodule

// File: tb/tb_pkt_ram_streamer.sv
// Randomized bench for pkt_ram_streamer: a packet-level model built from the RAM image
// predicts read addresses, stream words, framing, completion and error pulses.
module tb_pkt_ram_streamer;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          send_cmd;
   logic [AW-1:0] start_ram_addr;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic          st_valid;
   logic [DW-1:0] st_data;
   logic          st_sop;
   logic          st_eop;
   logic          st_ready;
   logic          busy;
   logic          pkt_done;
   logic          len_err;
   logic [15:0]   pkt_count;

   pkt_ram_streamer #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .send_cmd       (send_cmd),
      .start_ram_addr (start_ram_addr),
      .ram_rd_en      (ram_rd_en),
      .ram_rd_addr    (ram_rd_addr),
      .ram_rd_data    (ram_rd_data),
      .st_valid       (st_valid),
      .st_data        (st_data),
      .st_sop         (st_sop),
      .st_eop         (st_eop),
      .st_ready       (st_ready),
      .busy           (busy),
      .pkt_done       (pkt_done),
      .len_err        (len_err),
      .pkt_count      (pkt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packet RAM with one-cycle read latency; garbage when not reading.
   logic [DW-1:0] ram [64];
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
      else ram_rd_data <= $urandom;
   end

   // Ready driver: 0 = always 1, 1 = random, 2 = pattern 1,0,0 repeating.
   int ready_mode = 0;
   initial begin
      int phase;
      phase = 0;
      st_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: st_ready = 1'b1;
            1: st_ready = ($urandom_range(0, 3) != 0);
            default: st_ready = (phase == 0);
         endcase
         phase = (phase + 1) % 3;
      end
   end

   // Packet-level model state
   int            cyc = 0;
   bit            m_busy = 0;
   int            m_start = -100;
   logic [AW-1:0] m_start_addr = '0;
   int            m_len = 0;
   int            m_done_due = -1;
   int            m_err_due = -1;
   int            m_issued = 0;
   int            m_sent = 0;
   bit            m_hdr_seen = 0;
   bit            m_ready_all = 0;
   int            m_count = 0;
   bit            m_prev_send = 0;
   logic [AW-1:0] m_addrq [$];
   logic [DW+1:0] m_wordq [$];
   logic [DW-1:0] log_words [$];
   logic [AW-1:0] log_addrs [$];
   int            last_done_delta = -1;
   int            last_err_delta = -1;
   bit            pv = 0;
   bit            pr = 0;
   logic [DW+1:0] pw = '0;
   logic [AW-1:0] ta;
   logic [DW+1:0] tw;

   task automatic model_reset();
      m_busy = 0;
      m_start = -100;
      m_len = 0;
      m_done_due = -1;
      m_err_due = -1;
      m_count = 0;
      m_prev_send = 0;
      pv = 0;
      m_addrq.delete();
      m_wordq.delete();
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_outputs", {st_valid, busy, pkt_done, len_err, ram_rd_en, st_sop, st_eop}, 0);
         chk("rst_count", pkt_count, 0);
         model_reset();
      end else begin
         if (cyc == m_done_due) begin
            m_busy = 0;
            m_count++;
            last_done_delta = cyc - m_start;
            chk("all_reads_issued", m_addrq.size(), 0);
            if (m_ready_all) chk("done_timing", cyc - m_start, m_len + 5);
         end
         if (cyc == m_err_due) begin
            m_busy = 0;
            last_err_delta = cyc - m_start;
         end
         chk("busy", busy, m_busy);
         chk("pkt_done", pkt_done, cyc == m_done_due);
         chk("len_err", len_err, cyc == m_err_due);
         chk("pkt_count", pkt_count, m_count);
         if (m_busy && cyc == m_start + 1)
            chk("hdr_read", {ram_rd_en, ram_rd_addr}, {1'b1, m_start_addr});
         if (m_busy && cyc == m_start + 2) chk("no_read_wait_hdr", ram_rd_en, 0);
         if (m_busy && m_len > 0 && cyc == m_start + 3) chk("first_payload_read", ram_rd_en, 1);
         if (ram_rd_en) begin
            if (m_addrq.size() == 0) begin
               chk("spurious_read", ram_rd_en, 0);
            end else begin
               ta = m_addrq.pop_front();
               chk("rd_addr", ram_rd_addr, ta);
               log_addrs.push_back(ram_rd_addr);
               if (m_hdr_seen) m_issued++;
               m_hdr_seen = 1;
            end
         end
         if (!m_busy) chk("idle_no_valid", st_valid, 0);
         if (m_ready_all && m_busy && m_len > 0 && cyc >= m_start + 5 && cyc <= m_start + 4 + m_len)
         begin
            chk("full_rate_valid", st_valid, 1);
            chk("full_rate_index", m_sent, cyc - m_start - 5);
         end
         if (pv && !pr) chk("stall_hold", {st_valid, st_sop, st_eop, st_data}, {1'b1, pw});
         if (st_valid) begin
            if (m_wordq.size() == 0) begin
               chk("unexpected_valid", st_valid, 0);
            end else begin
               chk("word", {st_sop, st_eop, st_data}, m_wordq[0]);
               if (st_ready) begin
                  tw = m_wordq.pop_front();
                  m_sent++;
                  log_words.push_back(st_data);
                  if (tw[DW]) m_done_due = cyc + 1;
               end
            end
         end
         if (m_busy) chk("outstanding_le2", (m_issued - m_sent) <= 2, 1);
         if (m_busy && !st_ready) m_ready_all = 0;
         pv = st_valid;
         pr = st_ready;
         pw = {st_sop, st_eop, st_data};
         if (send_cmd && !m_prev_send && !m_busy) begin
            m_busy = 1;
            m_start = cyc;
            m_start_addr = start_ram_addr;
            m_len = int'(ram[start_ram_addr][5:0]);
            m_done_due = -1;
            m_err_due = (m_len == 0) ? cyc + 3 : -1;
            m_issued = 0;
            m_sent = 0;
            m_hdr_seen = 0;
            m_ready_all = 1;
            m_addrq.delete();
            m_wordq.delete();
            m_addrq.push_back(start_ram_addr);
            for (int i = 1; i <= m_len; i++) begin
               ta = start_ram_addr + AW'(i);
               m_addrq.push_back(ta);
               m_wordq.push_back({(i == 1), (i == m_len), ram[ta]});
            end
         end
         m_prev_send = send_cmd;
      end
   end

   task automatic start_pkt(input logic [AW-1:0] addr);
      @(posedge clk);
      #1;
      send_cmd = 1'b0;
      start_ram_addr = addr;
      @(posedge clk);
      #1;
      send_cmd = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((busy || m_busy) && n < budget);
      if (busy || m_busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic clear_logs();
      log_words.delete();
      log_addrs.delete();
      last_done_delta = -1;
      last_err_delta = -1;
   endtask

   logic [DW-1:0] exp_w [5];
   logic [AW-1:0] exp_a [5];
   int            ra;
   int            rl;
   int            n;

   initial begin
      rst = 1'b1;
      send_cmd = 1'b0;
      start_ram_addr = '0;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic packet at address 5, length 4 (upper header bits are junk)
      ram[5] = 32'hDEAD_BEC4;
      ram[6] = 32'hA1; ram[7] = 32'hA2; ram[8] = 32'hA3; ram[9] = 32'hA4;
      exp_w = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
      exp_a = '{6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
      clear_logs();
      start_pkt(5);
      wait_idle(200);
      chk("t1_nwords", log_words.size(), 4);
      chk("t1_naddrs", log_addrs.size(), 5);
      if (log_words.size() == 4)
         for (int i = 0; i < 4; i++) chk("t1_data", log_words[i], exp_w[i]);
      if (log_addrs.size() == 5)
         for (int i = 0; i < 5; i++) chk("t1_addr", log_addrs[i], exp_a[i]);
      chk("t1_done_delta", last_done_delta, 9);
      chk("t1_count", pkt_count, 1);

      // Address wrap: header at 62, length 3
      ram[62] = 32'h1234_5643;
      ram[63] = 32'hB1; ram[0] = 32'hB2; ram[1] = 32'hB3;
      exp_w = '{32'hB1, 32'hB2, 32'hB3, 32'h0, 32'h0};
      exp_a = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd0};
      clear_logs();
      start_pkt(62);
      wait_idle(200);
      chk("t2_naddrs", log_addrs.size(), 4);
      chk("t2_nwords", log_words.size(), 3);
      if (log_addrs.size() == 4)
         for (int i = 0; i < 4; i++) chk("t2_addr", log_addrs[i], exp_a[i]);
      if (log_words.size() == 3)
         for (int i = 0; i < 3; i++) chk("t2_data", log_words[i], exp_w[i]);
      chk("t2_count", pkt_count, 2);

      // Backpressure pattern 1,0,0
      ram[20] = 32'h4;
      ram[21] = 32'hC1; ram[22] = 32'hC2; ram[23] = 32'hC3; ram[24] = 32'hC4;
      exp_w = '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'h0};
      ready_mode = 2;
      clear_logs();
      start_pkt(20);
      wait_idle(300);
      chk("t3_nwords", log_words.size(), 4);
      if (log_words.size() == 4)
         for (int i = 0; i < 4; i++) chk("t3_data", log_words[i], exp_w[i]);
      chk("t3_count", pkt_count, 3);
      ready_mode = 0;

      // Zero-length header
      ram[30] = 32'hFFFF_FFC0;
      clear_logs();
      start_pkt(30);
      wait_idle(200);
      chk("t4_err_delta", last_err_delta, 3);
      chk("t4_nwords", log_words.size(), 0);
      chk("t4_naddrs", log_addrs.size(), 1);
      chk("t4_count", pkt_count, 3);

      // Held-high send_cmd with a second edge while busy
      ram[40] = 32'h5;
      clear_logs();
      start_pkt(40);
      repeat (3) @(posedge clk);
      @(posedge clk); #1; send_cmd = 1'b0;
      @(posedge clk); #1; send_cmd = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      chk("t5_nwords", log_words.size(), 5);
      chk("t5_count", pkt_count, 4);
      chk("t5_idle", busy, 0);

      // Asynchronous reset mid-packet, then a fresh packet
      ram[50] = 32'h5;
      for (int i = 0; i < 5; i++) ram[51 + i] = 32'hD1 + i;
      clear_logs();
      start_pkt(50);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (m_sent < 2 && n < 50);
      chk("t6_reached_word2", m_sent, 2);
      @(posedge clk);
      #2;
      chk("t6_valid_before_rst", st_valid, 1);
      rst = 1'b1;
      #1;
      chk("t6_async_valid", st_valid, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_count", pkt_count, 0);
      send_cmd = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
      start_pkt(50);
      wait_idle(200);
      chk("t6_nwords", log_words.size(), 5);
      if (log_words.size() == 5) chk("t6_first", log_words[0], 32'hD1);
      chk("t6_count", pkt_count, 1);

      // Randomized packets, ready patterns and send_cmd/start noise during busy
      for (int it = 0; it < 25; it++) begin
         for (int k = 0; k < 64; k++) ram[k] = $urandom;
         ra = $urandom_range(0, 63);
         rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
         ram[ra] = ($urandom & 32'hFFFF_FFC0) | 32'(rl);
         ready_mode = $urandom_range(0, 2);
         start_pkt(AW'(ra));
         repeat (2) begin
            @(posedge clk);
            #1;
            send_cmd = 1'($urandom_range(0, 1));
            start_ram_addr = AW'($urandom);
         end
         wait_idle(1000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
